// File: rtl/psg_mix_pkg.sv
// psg_mix_pkg: shared types, constants and the panning matrix for the PSG stereo mixer.
package psg_mix_pkg;

   localparam int SUM_W    = 10;
   localparam int MIDPOINT = 383;

   typedef enum logic [1:0] {MONO = 2'd0, ABC = 2'd1, ACB = 2'd2} stereo_mode_t;

   typedef struct packed {
      logic [SUM_W-1:0] l;
      logic [SUM_W-1:0] r;
   } mix_t;

   // STEREO=11 is an alias for mono
   function automatic stereo_mode_t decode_mode(input logic [1:0] stereo);
      return stereo == 2'b01 ? ABC : stereo == 2'b10 ? ACB : MONO;
   endfunction

   function automatic mix_t mix_matrix(input stereo_mode_t mode, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [SUM_W-1:0] ea, eb, ec;
      mix_t m;
      ea  = SUM_W'(a);
      eb  = SUM_W'(b);
      ec  = SUM_W'(c);
      m.l = mode == ABC ? (ea << 1) + eb : mode == ACB ? (ea << 1) + ec : ea + eb + ec;
      m.r = mode == ABC ? eb + (ec << 1) : mode == ACB ? (eb << 1) + ec : ea + eb + ec;
      return m;
   endfunction

endpackage

// File: rtl/psg_mix_accum.sv
// psg_mix_accum: one-channel box-car accumulator with averaging, DC removal and scaling.
module psg_mix_accum
   import psg_mix_pkg::*;
#(
   parameter int DECIM = 8,
   parameter int OUT_W = 16
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    clear,
   input  logic                    step,
   input  logic                    last,
   input  logic [SUM_W-1:0]        sample,
   output logic signed [OUT_W-1:0] pcm
);

   localparam int LG    = $clog2(DECIM);
   localparam int ACC_W = SUM_W + LG;

   logic [ACC_W-1:0] acc, acc_next;
   logic [SUM_W-1:0] avg;
   logic signed [10:0] dc;

   // pcm reflects the window including the current sample, so it is valid on the completing CE
   assign acc_next = acc + ACC_W'(sample);
   assign avg      = SUM_W'(acc_next >> LG);
   assign dc       = $signed({1'b0, avg}) - $signed(11'(MIDPOINT));
   assign pcm      = {dc, {(OUT_W - 11){1'b0}}};

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (step)
         acc <= last ? '0 : acc_next;

endmodule

// File: rtl/psg_stereo_mix.sv
// psg_stereo_mix: pans three PSG channels to stereo, decimates by DECIM and presents
// signed PCM samples over a valid/ready handshake with a sticky overrun flag.
module psg_stereo_mix
   import psg_mix_pkg::*;
#(
   parameter int DECIM = 8,
   parameter int OUT_W = 16
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    CE,
   input  logic                    ENABLE,
   input  logic [1:0]              STEREO,
   input  logic [7:0]              CH_A,
   input  logic [7:0]              CH_B,
   input  logic [7:0]              CH_C,
   output logic signed [OUT_W-1:0] OUT_L,
   output logic signed [OUT_W-1:0] OUT_R,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic                    OVERRUN
);

   localparam int LG = $clog2(DECIM);

   logic [LG-1:0] cnt;
   stereo_mode_t mode_q, mode_eff;
   mix_t mix;
   logic step, last, done;
   logic signed [OUT_W-1:0] pcm_l, pcm_r;

   // the first CE of a window uses STEREO directly and latches it for the rest of the window
   assign mode_eff = cnt == '0 ? decode_mode(STEREO) : mode_q;
   assign mix      = mix_matrix(mode_eff, CH_A, CH_B, CH_C);
   assign step     = CE & ENABLE;
   assign last     = cnt == LG'(DECIM - 1);
   assign done     = step & last;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         cnt    <= '0;
         mode_q <= MONO;
      end else if (!ENABLE)
         cnt <= '0;
      else if (CE) begin
         cnt <= cnt + LG'(1);
         if (cnt == '0)
            mode_q <= mode_eff;
      end

   psg_mix_accum #(.DECIM(DECIM), .OUT_W(OUT_W)) u_acc_l (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .clear  (!ENABLE),
      .step   (step),
      .last   (last),
      .sample (mix.l),
      .pcm    (pcm_l)
   );

   psg_mix_accum #(.DECIM(DECIM), .OUT_W(OUT_W)) u_acc_r (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .clear  (!ENABLE),
      .step   (step),
      .last   (last),
      .sample (mix.r),
      .pcm    (pcm_r)
   );

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         OUT_L     <= '0;
         OUT_R     <= '0;
         OUT_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else if (done) begin
         OUT_L     <= pcm_l;
         OUT_R     <= pcm_r;
         OUT_VALID <= 1'b1;
         if (OUT_VALID && !OUT_READY)
            OVERRUN <= 1'b1;
      end else if (OUT_VALID && OUT_READY)
         OUT_VALID <= 1'b0;

endmodule

// File: tb/tb_psg_stereo_mix.sv
// tb_psg_stereo_mix: directed scoreboard bench for psg_stereo_mix (DECIM=8, OUT_W=16).
module tb_psg_stereo_mix;

   logic CLK = 1'b0, RESET_N = 1'b0, CE = 1'b0, ENABLE = 1'b0, OUT_READY = 1'b0;
   logic [1:0] STEREO = 2'b00;
   logic [7:0] CH_A = '0, CH_B = '0, CH_C = '0;
   logic signed [15:0] OUT_L, OUT_R;
   logic OUT_VALID, OVERRUN;

   typedef struct {
      int l;
      int r;
   } smp_t;

   smp_t exp_q[$];
   int compared = 0, mismatched = 0;

   always #5 CLK = ~CLK;

   psg_stereo_mix #(.DECIM(8), .OUT_W(16)) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .CE       (CE),
      .ENABLE   (ENABLE),
      .STEREO   (STEREO),
      .CH_A     (CH_A),
      .CH_B     (CH_B),
      .CH_C     (CH_C),
      .OUT_L    (OUT_L),
      .OUT_R    (OUT_R),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .OVERRUN  (OVERRUN)
   );

   // constant inputs over a window make the average equal to the per-sample sum
   function automatic int scale(int sum);
      return (sum - 383) * 32;
   endfunction

   function automatic smp_t model(logic [1:0] st, int a, int b, int c);
      smp_t s;
      if (st == 2'b01) begin
         s.l = scale(2 * a + b);
         s.r = scale(b + 2 * c);
      end else if (st == 2'b10) begin
         s.l = scale(2 * a + c);
         s.r = scale(2 * b + c);
      end else begin
         s.l = scale(a + b + c);
         s.r = s.l;
      end
      return s;
   endfunction

   task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] want);
      compared++;
      assert (got === want)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic ce_n(int n, logic [7:0] a, logic [7:0] b, logic [7:0] c);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         CE   = 1'b1;
         CH_A = a;
         CH_B = b;
         CH_C = c;
      end
      @(negedge CLK);
      CE = 1'b0;
   endtask

   task automatic expect_front(string tag);
      chk({tag, "_valid"}, OUT_VALID, 1);
      chk({tag, "_qsize"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         chk({tag, "_L"}, OUT_L, exp_q[0].l);
         chk({tag, "_R"}, OUT_R, exp_q[0].r);
      end
   endtask

   task automatic accept(string tag);
      expect_front(tag);
      if (exp_q.size() > 0)
         void'(exp_q.pop_front());
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      chk({tag, "_cleared"}, OUT_VALID, 0);
   endtask

   initial begin
      // reset with random activity on the inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         CE        = 1'($urandom);
         ENABLE    = 1'($urandom);
         STEREO    = 2'($urandom);
         CH_A      = 8'($urandom);
         CH_B      = 8'($urandom);
         CH_C      = 8'($urandom);
         OUT_READY = 1'($urandom);
      end
      chk("rst_L", OUT_L, 0);
      chk("rst_R", OUT_R, 0);
      chk("rst_valid", OUT_VALID, 0);
      chk("rst_overrun", OVERRUN, 0);
      CE        = 1'b0;
      ENABLE    = 1'b1;
      OUT_READY = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;

      // ABC, A only
      STEREO = 2'b01;
      exp_q.push_back(model(2'b01, 255, 0, 0));
      ce_n(7, 8'd255, 8'd0, 8'd0);
      chk("abc_early_valid", OUT_VALID, 0);
      ce_n(1, 8'd255, 8'd0, 8'd0);
      chk("abc_L_const", OUT_L, 4064);
      chk("abc_R_const", OUT_R, -12256);
      accept("abc");

      // mono full scale, mono alias, mono zero
      STEREO = 2'b00;
      exp_q.push_back(model(2'b00, 255, 255, 255));
      ce_n(8, 8'd255, 8'd255, 8'd255);
      chk("mono_max_const", OUT_L, 12224);
      accept("mono_max");
      STEREO = 2'b11;
      exp_q.push_back(model(2'b11, 255, 255, 255));
      ce_n(8, 8'd255, 8'd255, 8'd255);
      accept("mono11_max");
      STEREO = 2'b00;
      exp_q.push_back(model(2'b00, 0, 0, 0));
      ce_n(8, 8'd0, 8'd0, 8'd0);
      chk("mono_min_const", OUT_R, -12256);
      accept("mono_min");

      // overrun: two unconsumed windows, then a simultaneous accept on the third
      exp_q.push_back(model(2'b00, 0, 0, 0));
      ce_n(8, 8'd0, 8'd0, 8'd0);
      chk("ovr_first_flag", OVERRUN, 0);
      void'(exp_q.pop_front());
      exp_q.push_back(model(2'b00, 255, 0, 0));
      ce_n(8, 8'd255, 8'd0, 8'd0);
      chk("ovr_flag", OVERRUN, 1);
      expect_front("ovr_second");
      ce_n(7, 8'd255, 8'd255, 8'd255);
      CE        = 1'b1;
      OUT_READY = 1'b1;
      void'(exp_q.pop_front());
      exp_q.push_back(model(2'b00, 255, 255, 255));
      @(negedge CLK);
      CE        = 1'b0;
      OUT_READY = 1'b0;
      chk("ovr_sticky", OVERRUN, 1);
      accept("ovr_third");

      // mode change mid-window takes effect from the next window
      STEREO = 2'b01;
      exp_q.push_back(model(2'b01, 255, 255, 0));
      ce_n(3, 8'd255, 8'd255, 8'd0);
      STEREO = 2'b10;
      ce_n(5, 8'd255, 8'd255, 8'd0);
      accept("switch_abc");
      exp_q.push_back(model(2'b10, 255, 255, 0));
      ce_n(8, 8'd255, 8'd255, 8'd0);
      accept("switch_acb");

      // ENABLE=0 discards the partial window but keeps a pending sample
      STEREO = 2'b00;
      exp_q.push_back(model(2'b00, 0, 0, 0));
      ce_n(8, 8'd0, 8'd0, 8'd0);
      ce_n(5, 8'd0, 8'd0, 8'd0);
      @(negedge CLK);
      ENABLE = 1'b0;
      CE     = 1'b1;
      repeat (2) @(negedge CLK);
      CE     = 1'b0;
      ENABLE = 1'b1;
      chk("en_pending_valid", OUT_VALID, 1);
      ce_n(7, 8'd255, 8'd255, 8'd255);
      accept("en_pending");
      exp_q.push_back(model(2'b00, 255, 255, 255));
      ce_n(1, 8'd255, 8'd255, 8'd255);
      accept("en_restart");

      // reset in the middle of a window with a pending sample
      exp_q.push_back(model(2'b00, 255, 255, 255));
      ce_n(8, 8'd255, 8'd255, 8'd255);
      ce_n(3, 8'd0, 8'd0, 8'd0);
      RESET_N = 1'b0;
      #1;
      chk("midrst_valid", OUT_VALID, 0);
      chk("midrst_L", OUT_L, 0);
      chk("midrst_overrun", OVERRUN, 0);
      void'(exp_q.pop_front());
      @(negedge CLK);
      RESET_N = 1'b1;
      exp_q.push_back(model(2'b00, 100, 50, 0));
      ce_n(7, 8'd100, 8'd50, 8'd0);
      chk("postrst_early_valid", OUT_VALID, 0);
      ce_n(1, 8'd100, 8'd50, 8'd0);
      accept("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
